mv_run_sequencer: RTL

// - Top-level sequencer for the 6x6 matrix-vector engine controller. Accepts start/abort from the host register file,

---
 rtl/mv_pkg.sv | 18 +
 rtl/mv_run_sequencer_if.sv | 57 +++++
 rtl/mv_bram_mux.sv | 33 +++
 rtl/mv_run_sequencer.sv | 137 +++++++++++++
 4 files changed

// File: rtl/mv_pkg.sv
// Shared types and widths for the matrix-vector run sequencer slice.
package mv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int unsigned MADDR_W = 12;
    localparam int unsigned VADDR_W = 10;
    localparam int unsigned WIDTH_W = 9;
    localparam int unsigned ITER_W  = 16;
    localparam int unsigned CYC_W   = 32;

endpackage

// File: rtl/mv_run_sequencer_if.sv
// Host, engine-controller and BRAM-side signals of the run sequencer.
interface mv_run_sequencer_if;
    import mv_pkg::*;

    logic                 start;
    logic                 abort;
    logic [WIDTH_W-1:0]   cfg_width;
    logic [ITER_W-1:0]    cfg_iteration;
    logic                 host_req;
    logic                 host_sel;
    logic                 host_we;
    logic [MADDR_W-1:0]   host_addr;
    logic                 host_grant;
    logic                 ctrl_running;
    logic [WIDTH_W-1:0]   ctrl_width;
    logic [ITER_W-1:0]    ctrl_iteration;
    logic                 ctrl_finish;
    logic                 ctrl_m_en;
    logic                 ctrl_m_we;
    logic [MADDR_W-1:0]   ctrl_m_addr;
    logic                 ctrl_v_en;
    logic                 ctrl_v_we;
    logic [VADDR_W-1:0]   ctrl_v_addr;
    logic                 mbram_en;
    logic                 mbram_we;
    logic [MADDR_W-1:0]   mbram_addr;
    logic                 vbram_en;
    logic                 vbram_we;
    logic [VADDR_W-1:0]   vbram_addr;
    logic                 busy;
    logic                 done;
    logic                 aborted;
    logic                 err;
    logic                 irq;
    logic [CYC_W-1:0]     run_cycles;

    modport slave (
        input  start, abort, cfg_width, cfg_iteration,
        input  host_req, host_sel, host_we, host_addr,
        input  ctrl_finish, ctrl_m_en, ctrl_m_we, ctrl_m_addr,
        input  ctrl_v_en, ctrl_v_we, ctrl_v_addr,
        output host_grant, ctrl_running, ctrl_width, ctrl_iteration,
        output mbram_en, mbram_we, mbram_addr, vbram_en, vbram_we, vbram_addr,
        output busy, done, aborted, err, irq, run_cycles
    );

    modport master (
        output start, abort, cfg_width, cfg_iteration,
        output host_req, host_sel, host_we, host_addr,
        output ctrl_finish, ctrl_m_en, ctrl_m_we, ctrl_m_addr,
        output ctrl_v_en, ctrl_v_we, ctrl_v_addr,
        input  host_grant, ctrl_running, ctrl_width, ctrl_iteration,
        input  mbram_en, mbram_we, mbram_addr, vbram_en, vbram_we, vbram_addr,
        input  busy, done, aborted, err, irq, run_cycles
    );

endinterface

// File: rtl/mv_bram_mux.sv
// Combinational BRAM port select: host side when granted, engine side otherwise.
module mv_bram_mux #(
    parameter int unsigned AW = 12
) (
    input  logic          host_grant_i,
    input  logic          host_target_i,
    input  logic          host_req_i,
    input  logic          host_we_i,
    input  logic [AW-1:0] host_addr_i,
    input  logic          eng_en_i,
    input  logic          eng_we_i,
    input  logic [AW-1:0] eng_addr_i,
    output logic          bram_en_o,
    output logic          bram_we_o,
    output logic [AW-1:0] bram_addr_o
);

    always_comb begin
        bram_en_o   = 1'b0;
        bram_we_o   = 1'b0;
        bram_addr_o = '0;
        if (!host_grant_i) begin
            bram_en_o   = eng_en_i;
            bram_we_o   = eng_we_i;
            bram_addr_o = eng_addr_i;
        end else if (host_target_i) begin
            bram_en_o   = host_req_i;
            bram_we_o   = host_req_i & host_we_i;
            bram_addr_o = host_addr_i;
        end
    end

endmodule

// File: rtl/mv_run_sequencer.sv
// Run sequencer for the 6x6 matrix-vector engine: config check, run/drain FSM,
// status and cycle counting, and state-based BRAM port arbitration.
module mv_run_sequencer
    import mv_pkg::*;
#(
    parameter int unsigned WIDTH_STEP = 6,
    parameter int unsigned WIDTH_MIN  = 6,
    parameter int unsigned WIDTH_MAX  = 384,
    parameter int unsigned DRAIN_CYC  = 2
) (
    input  logic                clk,
    input  logic                rst,
    mv_run_sequencer_if.slave   bus
);

    localparam logic [WIDTH_W-1:0] W_STEP     = WIDTH_W'(WIDTH_STEP);
    localparam logic [WIDTH_W-1:0] W_MIN      = WIDTH_W'(WIDTH_MIN);
    localparam logic [WIDTH_W-1:0] W_MAX      = WIDTH_W'(WIDTH_MAX);
    localparam logic [7:0]         DRAIN_LAST = 8'(DRAIN_CYC - 1);

    state_t               state_q;
    logic [WIDTH_W-1:0]   width_q;
    logic [ITER_W-1:0]    iter_q;
    logic [CYC_W-1:0]     cycles_q;
    logic [7:0]           drain_cnt_q;
    logic                 done_q;
    logic                 aborted_q;
    logic                 err_q;
    logic                 irq_q;
    logic                 cfg_ok;
    logic                 grant;
    logic                 unused_host_addr_hi;

    assign cfg_ok = (width_q >= W_MIN) && (width_q <= W_MAX) &&
                    ((width_q % W_STEP) == '0) && (iter_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            width_q     <= '0;
            iter_q      <= '0;
            cycles_q    <= '0;
            drain_cnt_q <= '0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            err_q       <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            irq_q <= 1'b0;
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state_q   <= ST_CHECK;
                        width_q   <= bus.cfg_width;
                        iter_q    <= bus.cfg_iteration;
                        cycles_q  <= '0;
                        done_q    <= 1'b0;
                        aborted_q <= 1'b0;
                        err_q     <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (cfg_ok) begin
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                        err_q   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cycles_q != '1) cycles_q <= cycles_q + 32'd1;
                    // finish takes priority: a coincident abort still counts as a normal completion
                    if (bus.ctrl_finish || bus.abort) begin
                        state_q     <= ST_DRAIN;
                        drain_cnt_q <= '0;
                        aborted_q   <= bus.abort && !bus.ctrl_finish;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_q <= ST_DONE;
                        done_q  <= !aborted_q;
                        irq_q   <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 8'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // running is masked by rst so the engine stops in the reset cycle itself
    assign bus.ctrl_running   = (state_q == ST_RUN) && !rst;
    assign grant              = (state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                (state_q == ST_CHECK);
    assign bus.host_grant     = grant;
    assign bus.busy           = (state_q == ST_CHECK) || (state_q == ST_RUN) ||
                                (state_q == ST_DRAIN);
    assign bus.ctrl_width     = width_q;
    assign bus.ctrl_iteration = iter_q;
    assign bus.done           = done_q;
    assign bus.aborted        = aborted_q;
    assign bus.err            = err_q;
    assign bus.irq            = irq_q;
    assign bus.run_cycles     = cycles_q;
    assign unused_host_addr_hi = ^bus.host_addr[MADDR_W-1:VADDR_W];

    mv_bram_mux #(.AW(MADDR_W)) u_mmux (
        .host_grant_i  (grant),
        .host_target_i (!bus.host_sel),
        .host_req_i    (bus.host_req),
        .host_we_i     (bus.host_we),
        .host_addr_i   (bus.host_addr),
        .eng_en_i      (bus.ctrl_m_en),
        .eng_we_i      (bus.ctrl_m_we),
        .eng_addr_i    (bus.ctrl_m_addr),
        .bram_en_o     (bus.mbram_en),
        .bram_we_o     (bus.mbram_we),
        .bram_addr_o   (bus.mbram_addr)
    );

    mv_bram_mux #(.AW(VADDR_W)) u_vmux (
        .host_grant_i  (grant),
        .host_target_i (bus.host_sel),
        .host_req_i    (bus.host_req),
        .host_we_i     (bus.host_we),
        .host_addr_i   (bus.host_addr[VADDR_W-1:0]),
        .eng_en_i      (bus.ctrl_v_en),
        .eng_we_i      (bus.ctrl_v_we),
        .eng_addr_i    (bus.ctrl_v_addr),
        .bram_en_o     (bus.vbram_en),
        .bram_we_o     (bus.vbram_we),
        .bram_addr_o   (bus.vbram_addr)
    );

endmodule
